rotary_multi: RTL and testbench

ROTARY_MULTI -- requirements
Module: rotary_multi

---
 rtl/rotary_multi.sv | 141 ++++++++++++++
 tb/tb_rotary_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_multi.sv
`default_nettype none
// ============================================================================
// Module   : rotary_multi
// Brief    : Multi-channel quadrature decoder with debounce, acceleration
//            and wrapping or saturating position counters.
// Revision : 1.0
// ============================================================================
module rotary_multi #(
    parameter int CHANNELS    = 2,
    parameter int POS_W       = 8,
    parameter int DEBOUNCE    = 16,
    parameter int SAT_MODE    = 0,
    parameter int FAST_WINDOW = 1000,
    parameter int FAST_STEP   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2*CHANNELS-1:0]     rotary_in,
    input  logic [CHANNELS-1:0]       zero,
    output logic [CHANNELS*POS_W-1:0] rotary_pos,
    output logic [CHANNELS-1:0]       rot_cw,
    output logic [CHANNELS-1:0]       rot_ccw,
    output logic                      any_event
);

    localparam int c_bits  = 2 * CHANNELS;
    localparam int c_cnt_w = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
    localparam int c_gap_w = (FAST_WINDOW < 1) ? 1 : $clog2(FAST_WINDOW + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE - 1);
    localparam logic [c_gap_w-1:0] c_gap_max  = c_gap_w'(FAST_WINDOW);
    localparam logic [POS_W-1:0]   c_fast_inc = POS_W'(FAST_STEP);
    localparam logic [POS_W-1:0]   c_one      = POS_W'(1);

    logic [c_bits-1:0]   r_sync1;
    logic [c_bits-1:0]   r_sync2;
    logic [c_bits-1:0]   w_deb;
    logic [c_bits-1:0]   r_deb_d;
    logic [CHANNELS-1:0] w_step;
    logic                r_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_d <= '0;
            r_any   <= 1'b0;
        end else begin
            r_sync1 <= rotary_in;
            r_sync2 <= r_sync1;
            r_deb_d <= w_deb;
            r_any   <= |w_step;
        end
    end

    // The counter only runs while the synchronised level disagrees with the
    // accepted level, so any return to the old level restarts the qualification.
    for (genvar b = 0; b < c_bits; b++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_deb;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_deb <= 1'b0;
            end else if (r_sync2[b] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_cnt <= '0;
                r_deb <= r_sync2[b];
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end

        assign w_deb[b] = r_deb;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic               w_rise;
        logic               w_cw;
        logic               w_ccw;
        logic               w_fast;
        logic [POS_W-1:0]   w_inc;
        logic [POS_W:0]     w_sum;
        logic [POS_W:0]     w_dif;
        logic [POS_W-1:0]   w_add;
        logic [POS_W-1:0]   w_sub;
        logic [POS_W-1:0]   r_pos;
        logic [c_gap_w-1:0] r_gap;
        logic               r_dir;
        logic               r_cw;
        logic               r_ccw;

        assign w_rise = w_deb[2*c] & ~r_deb_d[2*c];
        assign w_cw   = w_rise & ~w_deb[2*c+1];
        assign w_ccw  = w_rise &  w_deb[2*c+1];
        // r_dir holds 1 for a previous ccw step, so it matches w_ccw on a repeat.
        assign w_fast = (r_gap < c_gap_max) && (r_dir == w_ccw);
        assign w_inc  = w_fast ? c_fast_inc : c_one;
        assign w_sum  = {1'b0, r_pos} + {1'b0, w_inc};
        assign w_dif  = {1'b0, r_pos} - {1'b0, w_inc};
        assign w_add  = (SAT_MODE != 0 && w_sum[POS_W]) ? '1 : w_sum[POS_W-1:0];
        assign w_sub  = (SAT_MODE != 0 && w_dif[POS_W]) ? '0 : w_dif[POS_W-1:0];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_pos <= '0;
                r_gap <= c_gap_max;
                r_dir <= 1'b0;
                r_cw  <= 1'b0;
                r_ccw <= 1'b0;
            end else begin
                r_cw  <= w_cw;
                r_ccw <= w_ccw;
                if (w_rise) begin
                    r_gap <= '0;
                    r_dir <= w_ccw;
                end else if (r_gap != c_gap_max) begin
                    r_gap <= r_gap + c_gap_w'(1);
                end
                if (zero[c]) begin
                    r_pos <= '0;
                end else if (w_cw) begin
                    r_pos <= w_add;
                end else if (w_ccw) begin
                    r_pos <= w_sub;
                end
            end
        end

        assign w_step[c]                   = w_rise;
        assign rotary_pos[POS_W*c +: POS_W] = r_pos;
        assign rot_cw[c]                   = r_cw;
        assign rot_ccw[c]                  = r_ccw;
    end

    assign any_event = r_any;

endmodule
`default_nettype wire

// File: tb/tb_rotary_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotary_multi
// Brief    : Self-checking bench for rotary_multi (wrapping and saturating).
// Revision : 1.0
// ============================================================================
module tb_rotary_multi;

    localparam int CH = 2;
    localparam int PW = 8;
    localparam int D  = 16;
    localparam int FW = 1000;
    localparam int FS = 4;
    localparam int NB = 2 * CH;
    localparam int M  = 256;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NB-1:0]   rin;
    logic [CH-1:0]   zin;
    logic [CH*PW-1:0] pos_w, pos_s;
    logic [CH-1:0]   cw_w, ccw_w, cw_s, ccw_s;
    logic            any_w, any_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rotary_multi #(.CHANNELS(CH), .POS_W(PW), .DEBOUNCE(D), .SAT_MODE(0),
                   .FAST_WINDOW(FW), .FAST_STEP(FS)) dut (
        .clk(clk), .reset_n(reset_n), .rotary_in(rin), .zero(zin),
        .rotary_pos(pos_w), .rot_cw(cw_w), .rot_ccw(ccw_w), .any_event(any_w));

    rotary_multi #(.CHANNELS(CH), .POS_W(PW), .DEBOUNCE(D), .SAT_MODE(1),
                   .FAST_WINDOW(FW), .FAST_STEP(FS)) dut_sat (
        .clk(clk), .reset_n(reset_n), .rotary_in(rin), .zero(zin),
        .rotary_pos(pos_s), .rot_cw(cw_s), .rot_ccw(ccw_s), .any_event(any_s));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // An input bit is accepted once D consecutive raw samples (taken two
    // edges earlier) all disagree with the accepted level.
    logic [NB-1:0] hq[$];
    logic [NB-1:0] m_deb, nd;
    logic [CH-1:0] m_rise, e_cw, e_ccw;
    int   m_last[CH];
    bit   m_prev[CH];
    bit   m_dir[CH];
    int   e_pw[CH], e_ps[CH];
    int   edge_n = 0;
    bit   model_ok = 0;
    bit   dir, fast, ad;
    int   inc;

    function automatic logic [31:0] exp_pack(input bit sat);
        logic [CH*PW-1:0] p;
        for (int c = 0; c < CH; c++) p[PW*c +: PW] = sat ? PW'(e_ps[c]) : PW'(e_pw[c]);
        return 32'({p, e_cw, e_ccw, |{e_cw, e_ccw}});
    endfunction

    always @(posedge clk) begin
        edge_n++;
        if (!reset_n) begin
            hq.delete();
            for (int j = 0; j < D + 2; j++) hq.push_back('0);
            m_deb = '0; m_rise = '0; e_cw = '0; e_ccw = '0;
            for (int c = 0; c < CH; c++) begin
                m_prev[c] = 0; m_dir[c] = 0; m_last[c] = 0; e_pw[c] = 0; e_ps[c] = 0;
            end
            model_ok = 1;
        end else if (model_ok) begin
            hq.push_back(rin);
            void'(hq.pop_front());
            e_cw = '0; e_ccw = '0;
            for (int c = 0; c < CH; c++) begin
                if (m_rise[c]) begin
                    dir  = m_deb[2*c+1];
                    fast = m_prev[c] && (edge_n - m_last[c] - 1 < FW) && (dir == m_dir[c]);
                    inc  = fast ? FS : 1;
                    if (dir) begin
                        e_ccw[c] = 1'b1;
                        e_pw[c]  = ((e_pw[c] - inc) % M + M) % M;
                        e_ps[c]  = (e_ps[c] - inc < 0) ? 0 : e_ps[c] - inc;
                    end else begin
                        e_cw[c] = 1'b1;
                        e_pw[c] = (e_pw[c] + inc) % M;
                        e_ps[c] = (e_ps[c] + inc > M - 1) ? M - 1 : e_ps[c] + inc;
                    end
                    m_prev[c] = 1; m_last[c] = edge_n; m_dir[c] = dir;
                end
                if (zin[c]) begin e_pw[c] = 0; e_ps[c] = 0; end
            end
            for (int b = 0; b < NB; b++) begin
                ad = 1;
                for (int j = 2; j <= D + 1; j++)
                    if (hq[hq.size() - 1 - j][b] == m_deb[b]) ad = 0;
                nd[b] = ad ? ~m_deb[b] : m_deb[b];
            end
            for (int c = 0; c < CH; c++) m_rise[c] = nd[2*c] & ~m_deb[2*c];
            m_deb = nd;
        end
        #1;
        if (model_ok) begin
            check("cycle_wrap", 32'({pos_w, cw_w, ccw_w, any_w}), exp_pack(0));
            check("cycle_sat",  32'({pos_s, cw_s, ccw_s, any_s}), exp_pack(1));
        end
    end

    // pulse counter on the saturating instance
    int pcount[CH];
    initial for (int c = 0; c < CH; c++) pcount[c] = 0;
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < CH; c++) if (cw_s[c] | ccw_s[c]) pcount[c]++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_step(input int ch, input bit ccw, input bit zero_it);
        @(negedge clk); rin[2*ch+1] = ccw;
        repeat (20) @(negedge clk);
        rin[2*ch] = 1'b1;
        repeat (18) @(negedge clk);
        if (zero_it) zin[ch] = 1'b1;
        @(negedge clk); zin[ch] = 1'b0;
        repeat (20) @(negedge clk); rin[2*ch] = 1'b0;
        repeat (20) @(negedge clk); rin[2*ch+1] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        int ch; bit ccw; int idle; int reps; bit zero_it; int exp_w; int exp_s;
    } step_t;
    step_t tbl[15];

    int first_e, width, p0;
    bit any_seen;

    initial begin
        tbl[0]  = '{0, 1, 0,    1,  0, 255, 0};
        tbl[1]  = '{0, 1, 100,  1,  0, 251, 0};
        tbl[2]  = '{0, 1, 2000, 1,  0, 250, 0};
        tbl[3]  = '{0, 0, 0,    1,  0, 251, 1};
        tbl[4]  = '{0, 0, 0,    1,  0, 255, 5};
        tbl[5]  = '{0, 0, 2000, 1,  0, 0,   6};
        tbl[6]  = '{0, 0, 2000, 1,  0, 1,   7};
        tbl[7]  = '{1, 0, 0,    1,  0, 1,   1};
        tbl[8]  = '{1, 0, 2000, 1,  0, 2,   2};
        tbl[9]  = '{1, 0, 0,    63, 0, 254, 254};
        tbl[10] = '{1, 0, 0,    1,  0, 2,   255};
        tbl[11] = '{1, 0, 0,    1,  0, 6,   255};
        tbl[12] = '{0, 0, 0,    1,  1, 0,   0};
        tbl[13] = '{0, 1, 0,    1,  0, 255, 0};
        tbl[14] = '{0, 1, 0,    1,  0, 251, 0};

        reset_n = 1'b0; rin = '0; zin = '0;
        repeat (3) @(negedge clk);
        check("reset_wrap", 32'({pos_w, cw_w, ccw_w, any_w}), 32'd0);
        check("reset_sat",  32'({pos_s, cw_s, ccw_s, any_s}), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // single cw step on ch0: pulse on the 19th edge, one cycle wide
        rin[0] = 1'b1;
        first_e = 0; width = 0; any_seen = 0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (cw_w[0]) begin
                if (first_e == 0) first_e = e;
                width++;
                any_seen = any_w;
            end
        end
        check("cw0_edge",  first_e, 19);
        check("cw0_width", width, 1);
        check("cw0_any",   32'(any_seen), 1);
        check("cw0_pos",   32'(pos_w[7:0]), 1);
        @(negedge clk); rin[0] = 1'b0;
        repeat (30) @(negedge clk);

        // 10-cycle glitch on ch1 A
        p0 = pcount[1];
        rin[2] = 1'b1;
        repeat (10) @(negedge clk);
        rin[2] = 1'b0;
        repeat (40) @(negedge clk);
        check("glitch_pulses", pcount[1] - p0, 0);
        check("glitch_pos1",   32'(pos_w[15:8]), 0);

        // reset in the middle of debouncing
        rin[0] = 1'b1;
        repeat (12) @(negedge clk);
        reset_n = 1'b0; rin[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_outs", 32'({pos_w, cw_w, ccw_w, any_w}), 32'd0);
        reset_n = 1'b1;
        p0 = pcount[0];
        repeat (60) @(negedge clk);
        check("midreset_nostep", pcount[0] - p0, 0);
        check("midreset_pos", 32'({pos_w, pos_s}), 32'd0);

        // table-driven step sequences
        for (int i = 0; i < 15; i++) begin
            repeat (tbl[i].idle) @(negedge clk);
            p0 = pcount[tbl[i].ch];
            for (int r = 0; r < tbl[i].reps; r++) do_step(tbl[i].ch, tbl[i].ccw, tbl[i].zero_it);
            check($sformatf("tbl%0d_pos_wrap", i), 32'(pos_w[PW*tbl[i].ch +: PW]), tbl[i].exp_w);
            check($sformatf("tbl%0d_pos_sat", i),  32'(pos_s[PW*tbl[i].ch +: PW]), tbl[i].exp_s);
            check($sformatf("tbl%0d_pulses", i),   pcount[tbl[i].ch] - p0, tbl[i].reps);
        end

        // randomized toggling on all bits against the model
        repeat (4000) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) if ($urandom_range(0, 19) == 0) rin[b] = ~rin[b];
            for (int c = 0; c < CH; c++) zin[c] = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk); zin = '0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
